// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// byte-offset mask used for word-alignment checks.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  localparam logic [1:0] ALIGN_MASK = 2'h3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// Word register file with byte-strobed synchronous write, asynchronous read
// and synchronous active-high clear.
module apb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) regs_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = regs_q[idx];

endmodule

// File: rtl/apb_completer.sv
// APB4 completer: setup/access FSM with programmable wait states, protocol
// violation detection, address decode errors and a byte-strobed register file.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [CNT_W-1:0]      WS_C   = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-3:0] NREG_C = (ADDR_WIDTH-2)'(NUM_REGS);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;

  logic                  rdy;
  logic                  dec_err;
  logic                  viol;
  logic                  we;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [DATA_WIDTH-1:0] rf_rdata;

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign dec_err  = ((addr_q[1:0] & ALIGN_MASK) != 2'b00) || (word_idx >= NREG_C);
  assign rdy      = (state_q == ACCESS) && (cnt_q == WS_C);
  assign viol     = !psel || !penable || (paddr != addr_q) || (pwrite != pwrite_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    pwrite_d = pwrite_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d   = paddr;
          pwrite_d = pwrite;
          wdata_d  = pwdata;
          strb_d   = pstrb;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!rdy) begin
          if (viol) state_d = ERR;
          else      cnt_d   = cnt_q + 1'b1;
        end else begin
          // A requester that abandons the completion cycle gets no commit,
          // but pready still lasts only one cycle.
          state_d = IDLE;
          we      = psel && penable && pwrite_q && !dec_err;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pwrite_q <= pwrite_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
    end
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .idx   (word_idx[IDX_W-1:0]),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .rdata (rf_rdata)
  );

  // Responses depend only on flopped state, never on the live bus inputs.
  assign pready  = rdy || (state_q == ERR);
  assign pslverr = (state_q == ERR) || (rdy && dec_err);
  assign prdata  = (rdy && !pwrite_q && !dec_err) ? rf_rdata : '0;

endmodule

// File: tb/tb_apb_completer.sv
// Self-checking bench: two completers (2 and 0 wait states) on a shared bus
// with separate selects, checked against an array model of the register file.
module tb_apb_completer;

  logic        pclk = 1'b0;
  logic        preset, psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  always #5 pclk = ~pclk;

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  logic [31:0] mem [2][16];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd16);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    if (model_err(a)) return 32'h0;
    return mem[d][a[5:2]];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
    if (!model_err(a))
      for (int b = 0; b < 4; b++)
        if (st[b]) mem[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
  endtask

  // Drives one transfer and returns what was seen in the pready cycle.
  // Bus is left selected so the following edge completes the transfer.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int lat, output logic pre_rdy);
    @(negedge pclk);
    pre_rdy = (d == 0) ? pready0 : pready1;
    psel0 = (d == 0); psel1 = (d == 1); penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    while (!((d == 0) ? pready0 : pready1) && lat < 20) begin
      @(negedge pclk);
      lat++;
    end
    rd = (d == 0) ? prdata0 : prdata1;
    er = (d == 0) ? pslverr0 : pslverr1;
    if (wr) model_write(d, a, wd, st);
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_clear();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    n_checks++;
    if ({pready0, pslverr0, prdata0} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_dut0: got rdy=%b err=%b rdata=%h, want 0 0 0", pready0, pslverr0, prdata0);
    end
    n_checks++;
    if ({pready1, pslverr1, prdata1} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: got rdy=%b err=%b rdata=%h, want 0 0 0", pready1, pslverr1, prdata1);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, pr; int lat;
    xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL wr_0x4: got err=%b lat=%0d, want 0 3", er, lat);
    end
    xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3 || pr !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_0x4: got rdata=%h err=%b lat=%0d pre=%b, want deadbeef 0 3 0", rd, er, lat, pr);
    end
    bus_idle();
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic er, pr; int lat;
    xfer(0, 1, 32'h8, 32'h11223344, 4'hF, rd, er, lat, pr);
    xfer(0, 1, 32'h8, 32'hAABBCCDD, 4'h5, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL strb_write: got err=%b rdata=%h, want 0 0", er, rd);
    end
    xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      n_fail++; $display("FAIL strb_read: got rdata=%h err=%b, want 11bb33dd 0", rd, er);
    end
    xfer(0, 1, 32'hC, 32'hFFFFFFFF, 4'h0, rd, er, lat, pr);
    xfer(0, 0, 32'hC, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== model_read(0, 32'hC) || er !== 1'b0) begin
      n_fail++; $display("FAIL strb_zero: got rdata=%h err=%b, want %h 0", rd, er, model_read(0, 32'hC));
    end
    bus_idle();
  endtask

  task automatic test_decode_err();
    logic [31:0] rd; logic er, pr; int lat;
    xfer(0, 1, 32'h1, 32'hCAFEF00D, 4'hF, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b1 || lat != 3) begin
      n_fail++; $display("FAIL misaligned_wr: got err=%b lat=%0d, want 1 3", er, lat);
    end
    xfer(0, 0, 32'h3, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin
      n_fail++; $display("FAIL misaligned_rd: got err=%b rdata=%h lat=%0d, want 1 0 3", er, rd, lat);
    end
    xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL reg0_untouched: got err=%b rdata=%h, want 0 0", er, rd);
    end
    xfer(0, 1, 32'h40, 32'h12345678, 4'hF, rd, er, lat, pr);
    xfer(0, 0, 32'h40, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL out_of_range: got err=%b rdata=%h, want 1 0", er, rd);
    end
    bus_idle();
  endtask

  // mode 0: psel dropped one cycle into access; mode 1: paddr changed
  task automatic test_violation(input int mode);
    logic [31:0] rd, a; logic er, pr; int lat;
    a = (mode == 0) ? 32'h4 : 32'h8;
    @(negedge pclk);
    psel0 = 1; psel1 = 0; penable = 0; pwrite = 1; paddr = a; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1;
    @(negedge pclk);
    if (mode == 0) begin psel0 = 0; penable = 0; end
    else paddr = a ^ 32'h10;
    @(negedge pclk);
    psel0 = 0; penable = 0;
    n_checks++;
    if (pready0 !== 1'b1 || pslverr0 !== 1'b1 || prdata0 !== 32'h0) begin
      n_fail++;
      $display("FAIL viol%0d_resp: got rdy=%b err=%b rdata=%h, want 1 1 0", mode, pready0, pslverr0, prdata0);
    end
    @(negedge pclk);
    n_checks++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      n_fail++; $display("FAIL viol%0d_oneshot: got rdy=%b err=%b, want 0 0", mode, pready0, pslverr0);
    end
    xfer(0, 0, a, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== model_read(0, a) || er !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL viol%0d_followup: got rdata=%h err=%b lat=%0d, want %h 0 3", mode, rd, er, lat, model_read(0, a));
    end
    bus_idle();
  endtask

  task automatic test_idle_penable();
    @(negedge pclk);
    psel0 = 1; penable = 1; pwrite = 0; paddr = 32'h4;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      n_fail++; $display("FAIL idle_penable: got rdy=%b err=%b, want 0 0", pready0, pslverr0);
    end
    psel0 = 0; penable = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, pr; int lat;
    @(negedge pclk);
    psel0 = 1; penable = 0; pwrite = 1; paddr = 32'hC; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1;
    @(negedge pclk);
    preset = 1;
    @(negedge pclk);
    preset = 0; psel0 = 0; penable = 0;
    model_clear();
    n_checks++;
    if ({pready0, pslverr0, prdata0} !== 34'h0) begin
      n_fail++; $display("FAIL reset_mid_out: got rdy=%b err=%b rdata=%h, want 0 0 0", pready0, pslverr0, prdata0);
    end
    xfer(0, 0, 32'hC, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_read: got rdata=%h err=%b, want 0 0", rd, er);
    end
    xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, lat, pr);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_clears_regs: got rdata=%h, want 0", rd);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd, a; logic er, pr; int lat;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      xfer(1, 1, 32'(i * 4), wd, 4'hF, rd, er, lat, pr);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'((i % 4) * 4);
      xfer(1, 0, a, 32'h0, 4'h0, rd, er, lat, pr);
      n_checks++;
      if (rd !== model_read(1, a) || er !== 1'b0 || lat != 1 || pr !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_rd%0d: got rdata=%h err=%b lat=%0d pre=%b, want %h 0 1 0", i, rd, er, lat, pr, model_read(1, a));
      end
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic er, pr, exp_er; logic [3:0] st; int lat, d, r; bit wr;
    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 32'($urandom_range(16, 1000) * 4);
      wd = $urandom;
      st = 4'($urandom);
      exp_er = model_err(a);
      exp_rd = wr ? 32'h0 : model_read(d, a);
      xfer(d, wr, a, wd, st, rd, er, lat, pr);
      n_checks++;
      if (rd !== exp_rd || er !== exp_er || lat != ((d == 0) ? 3 : 1) || pr !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d d%0d wr=%0b a=%h: got rdata=%h err=%b lat=%0d pre=%b, want %h %b %0d 0",
                 i, d, wr, a, rd, er, lat, pr, exp_rd, exp_er, (d == 0) ? 3 : 1);
      end
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_decode_err();
    test_violation(0);
    test_violation(1);
    test_idle_penable();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
